// File: rtl/sockit_cdc_pkg.sv
// Shared types and constants for the sockit CDC stream checker.
package sockit_cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] LFSR_SEED = 32'h00000001;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/sockit_lfsr.sv
// 32-bit Galois LFSR with step enable and synchronous seed load.
module sockit_lfsr
  import sockit_cdc_pkg::*;
#(
  parameter logic [31:0] SEED = LFSR_SEED
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_ld,
  output logic [31:0] o_q
);

  logic [31:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_ld) r_q <= SEED;
    else if (i_en)     r_q <= lfsr_step(r_q);
  end

  assign o_q = r_q;

endmodule

// File: rtl/sockit_cdc_chk.sv
// Stream sink checker: grants randomly, counts transfers, checks a counting pattern.
// Define SOCKIT_CDC_CHK_FIRST_ERR_EN to add first-mismatch capture ports sts_exp/sts_got.
module sockit_cdc_chk
  import sockit_cdc_pkg::*;
#(
  parameter int          DW   = 8,
  parameter int          CW   = 16,
  parameter logic [31:0] SEED = LFSR_SEED
) (
  input  logic          ffo_clk,
  input  logic          ffo_rst,
  input  logic [DW-1:0] ffo_bus,
  input  logic          ffo_req,
  output logic          ffo_grt,
  input  logic [31:0]   cfg_prb,
  input  logic [CW-1:0] cfg_len,
  input  logic          cmd_start,
  output logic          sts_busy,
  output logic          sts_done,
  output logic          sts_pass,
  output logic [CW-1:0] sts_trn,
  output logic [CW-1:0] sts_err
`ifdef SOCKIT_CDC_CHK_FIRST_ERR_EN
  ,
  output logic [DW-1:0] sts_exp,
  output logic [DW-1:0] sts_got
`endif
);

  state_t        r_state, w_state_nxt;
  logic          r_grt;
  logic [31:0]   r_prb;
  logic [CW-1:0] r_len, r_trn, r_err;
  logic [DW-1:0] r_exp;
  logic [31:0]   w_lfsr;
  logic          w_run, w_start, w_trn, w_last, w_mis;

  assign w_run   = (r_state == ST_RUN);
  assign w_start = cmd_start & ~w_run;
  assign w_trn   = ffo_req & r_grt;
  // Saturated r_trn + 1 wraps to 0, which never matches a nonzero length.
  assign w_last  = w_trn && (r_len != '0) && ((r_trn + CW'(1)) == r_len);
  // Case inequality so X/Z on the bus is flagged in simulation.
  assign w_mis   = (ffo_bus !== r_exp);

  sockit_lfsr #(.SEED(SEED)) u_lfsr (
    .i_clk (ffo_clk),
    .i_rst (ffo_rst),
    .i_en  (w_run),
    .i_ld  (w_start),
    .o_q   (w_lfsr)
  );

  always_ff @(posedge ffo_clk) begin
    if (ffo_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (cmd_start) w_state_nxt = ST_RUN;
      ST_RUN:           if (w_last)    w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ffo_clk) begin
    if (ffo_rst) begin
      r_grt <= 1'b0;
      r_prb <= '0;
      r_len <= '0;
      r_trn <= '0;
      r_err <= '0;
      r_exp <= '0;
    end else if (w_start) begin
      r_grt <= 1'b0;
      r_prb <= cfg_prb;
      r_len <= cfg_len;
      r_trn <= '0;
      r_err <= '0;
      r_exp <= '0;
    end else if (w_run) begin
      // A raised grant is held until the upstream takes it.
      if (w_last)               r_grt <= 1'b0;
      else if (!r_grt || w_trn) r_grt <= (w_lfsr < r_prb);
      if (w_trn) begin
        r_exp <= r_exp + DW'(1);
        if (r_trn != '1)          r_trn <= r_trn + CW'(1);
        if (w_mis && r_err != '1) r_err <= r_err + CW'(1);
      end
    end else begin
      r_grt <= 1'b0;
    end
  end

`ifdef SOCKIT_CDC_CHK_FIRST_ERR_EN
  logic [DW-1:0] r_fexp, r_fgot;

  always_ff @(posedge ffo_clk) begin
    if (ffo_rst || w_start) begin
      r_fexp <= '0;
      r_fgot <= '0;
    end else if (w_run && w_trn && w_mis && r_err == '0) begin
      r_fexp <= r_exp;
      r_fgot <= ffo_bus;
    end
  end

  assign sts_exp = r_fexp;
  assign sts_got = r_fgot;
`endif

  assign ffo_grt  = r_grt;
  assign sts_busy = w_run;
  assign sts_done = (r_state == ST_DONE);
  assign sts_pass = (r_state == ST_DONE) && (r_err == '0);
  assign sts_trn  = r_trn;
  assign sts_err  = r_err;

endmodule
